// File: rtl/mips_instr_encoder_if.sv
// Field-bundle / instruction-memory write bus for the MIPS instruction encoder.
// The master side produces decoded instruction descriptions and observes the
// memory writes; the slave side is the encoder itself.
interface mips_instr_encoder_if #(
  parameter int AW = 8
);
  logic          Start;
  logic          InValid;
  logic          InReady;
  logic          Last;
  logic [2:0]    Kind;
  logic [4:0]    Rs;
  logic [4:0]    Rt;
  logic [4:0]    Rd;
  logic [4:0]    Shamt;
  logic [5:0]    Funct;
  logic [15:0]   Imm;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [31:0]   WrData;
  logic [AW:0]   Count;
  logic          Done;
  logic          Error;

  modport master (
    output Start, InValid, Last, Kind, Rs, Rt, Rd, Shamt, Funct, Imm,
    input  InReady, WrEn, WrAddr, WrData, Count, Done, Error
  );

  modport slave (
    input  Start, InValid, Last, Kind, Rs, Rt, Rd, Shamt, Funct, Imm,
    output InReady, WrEn, WrAddr, WrData, Count, Done, Error
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Sequential MIPS instruction-stream writer. Each accepted field bundle is
// assembled into a 32-bit machine word and written to consecutive
// instruction-memory word addresses starting at BASE.
module mips_instr_encoder #(
  parameter int AW   = 8,
  parameter int BASE = 0
) (
  input logic                Clk,
  input logic                Rst_n,
  mips_instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [2:0] K_RTYPE  = 3'd0;
  localparam logic [2:0] K_LW     = 3'd1;
  localparam logic [2:0] K_SW     = 3'd2;
  localparam logic [2:0] K_BRANCH = 3'd3;
  localparam logic [2:0] K_ADDI   = 3'd4;
  localparam logic [2:0] K_ADDIU  = 3'd5;

  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_addr;
  logic          r_full;
  logic [AW:0]   r_count;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;

  logic          w_in_ready;
  logic          w_xfer;
  logic          w_legal;
  logic          w_overrun;
  logic [15:0]   w_off;
  logic [31:0]   w_word;

  // Start wins over any handshake, so the encoder never accepts in a Start cycle.
  assign w_in_ready = (r_state == S_RUN) & ~r_full & ~bus.Start;
  assign w_xfer     = bus.InValid & w_in_ready;
  assign w_legal    = (bus.Kind <= K_ADDIU);
  assign w_overrun  = (r_state == S_RUN) & r_full & bus.InValid & ~bus.Start;

  // Branch offset relative to the word after the one being written. Both
  // operands are below 2^15, so plain 16-bit subtraction equals the AW+1-bit
  // difference sign-extended to 16 bits.
  assign w_off = 16'(bus.Imm[AW-1:0]) - 16'(r_addr) - 16'd1;

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: Start restarts from anywhere; DONE and ERR are sticky.
  always_comb begin
    // NOTE: a default assignment at the top keeps every path assigned, so no
    // latch is inferred from the partial if/case below.
    w_state_nxt = r_state;
    if (bus.Start) begin
      w_state_nxt = S_RUN;
    end else if (r_state == S_RUN) begin
      if (w_overrun)                 w_state_nxt = S_ERR;
      else if (w_xfer && !w_legal)   w_state_nxt = S_ERR;
      else if (w_xfer && bus.Last)   w_state_nxt = S_DONE;
    end
  end

  // Output logic: status levels decode directly from the state register.
  always_comb begin
    bus.InReady = w_in_ready;
    bus.Done    = (r_state == S_DONE);
    bus.Error   = (r_state == S_ERR);
    bus.WrEn    = r_wr_en;
    bus.WrAddr  = r_wr_addr;
    bus.WrData  = r_wr_data;
    bus.Count   = r_count;
  end

  // Instruction-word assembly from the current field bundle.
  always_comb begin
    w_word = '0;
    case (bus.Kind)
      K_RTYPE:  w_word = {6'b000000, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, bus.Funct};
      K_LW:     w_word = {6'b100011, bus.Rs, bus.Rt, bus.Imm};
      K_SW:     w_word = {6'b101011, bus.Rs, bus.Rt, bus.Imm};
      K_BRANCH: w_word = {6'b000100, bus.Rs, bus.Rt, w_off};
      K_ADDI:   w_word = {6'b001000, bus.Rs, bus.Rt, bus.Imm};
      K_ADDIU:  w_word = {6'b001001, bus.Rs, bus.Rt, bus.Imm};
      default:  w_word = '0;
    endcase
  end

  // Write port, address pointer, word count and full flag.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_addr    <= BASE_ADDR;
      r_count   <= '0;
      r_full    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (bus.Start) begin
        r_addr  <= BASE_ADDR;
        r_count <= '0;
        r_full  <= 1'b0;
      end else if (w_xfer && w_legal) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_addr;
        r_wr_data <= w_word;
        r_count   <= r_count + CNT_ONE;
        // The top word fills the memory; the pointer parks there instead of wrapping.
        if (r_addr == LAST_ADDR) r_full <= 1'b1;
        else                     r_addr <= r_addr + ADDR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed bundles push their
// hand-computed write into a queue, and per-DUT monitors pop and compare on
// every WrEn. An AW=8 instance covers encoding/control, an AW=2 one the fill.
module tb_mips_instr_encoder;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  mips_instr_encoder_if #(.AW(8)) ifa ();
  mips_instr_encoder_if #(.AW(2)) ifb ();

  mips_instr_encoder #(.AW(8), .BASE(0)) dut_a (.Clk(Clk), .Rst_n(Rst_n), .bus(ifa.slave));
  mips_instr_encoder #(.AW(2), .BASE(0)) dut_b (.Clk(Clk), .Rst_n(Rst_n), .bus(ifb.slave));

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          count;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ea_addr = 0;
  int   ea_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor A: every write must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (ifa.WrEn === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_unexpected_wren", 32'(ifa.WrEn), 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_wr_addr", 32'(ifa.WrAddr), e.addr);
        check("a_wr_data", ifa.WrData, e.data);
        check("a_count",   32'(ifa.Count), e.count);
      end
    end
  end

  // Monitor B: same for the AW=2 instance.
  always @(negedge Clk) begin
    if (ifb.WrEn === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_unexpected_wren", 32'(ifb.WrEn), 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_wr_addr", 32'(ifb.WrAddr), e.addr);
        check("b_wr_data", ifb.WrData, e.data);
        check("b_count",   32'(ifb.Count), e.count);
      end
    end
  end

  task automatic start_a();
    ifa.Start   = 1'b1;
    ifa.InValid = 1'b0;
    ifa.Last    = 1'b0;
    @(negedge Clk);
    check("a_ready_in_start", 32'(ifa.InReady), 32'd0);
    @(posedge Clk);
    #1;
    ifa.Start = 1'b0;
    ea_addr   = 0;
    ea_cnt    = 0;
  endtask

  // Present one bundle and hold it until accepted; returns 1 time unit after the transfer edge.
  task automatic send_a(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic last, input logic [31:0] exp_data,
                        input bit push);
    int budget;
    ifa.Kind = kind; ifa.Rs = rs; ifa.Rt = rt; ifa.Rd = rd;
    ifa.Shamt = sh; ifa.Funct = fn; ifa.Imm = imm; ifa.Last = last;
    ifa.InValid = 1'b1;
    budget = 0;
    @(negedge Clk);
    while (ifa.InReady !== 1'b1 && budget < 20) begin
      budget++;
      @(negedge Clk);
    end
    if (budget >= 20) begin
      check("a_ready_timeout", 32'(ifa.InReady), 32'd1);
    end else if (push) begin
      qa.push_back('{ea_addr, exp_data, ea_cnt + 1});
      ea_addr++;
      ea_cnt++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.InValid = 1'b0;
    ifa.Last    = 1'b0;
  endtask

  logic [31:0] fill_word [4] = '{32'h00220020, 32'h00220820, 32'h00221020, 32'h00221820};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.Start = 0; ifa.InValid = 0; ifa.Last = 0; ifa.Kind = 0; ifa.Rs = 0; ifa.Rt = 0;
    ifa.Rd = 0; ifa.Shamt = 0; ifa.Funct = 0; ifa.Imm = 0;
    ifb.Start = 0; ifb.InValid = 0; ifb.Last = 0; ifb.Kind = 0; ifb.Rs = 0; ifb.Rt = 0;
    ifb.Rd = 0; ifb.Shamt = 0; ifb.Funct = 0; ifb.Imm = 0;

    // Reset values.
    #12;
    check("rst_inready", 32'(ifa.InReady), 0);
    check("rst_wren",    32'(ifa.WrEn), 0);
    check("rst_wraddr",  32'(ifa.WrAddr), 0);
    check("rst_wrdata",  ifa.WrData, 0);
    check("rst_count",   32'(ifa.Count), 0);
    check("rst_done",    32'(ifa.Done), 0);
    check("rst_error",   32'(ifa.Error), 0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;

    // Idle: InValid outside RUN is ignored.
    ifa.InValid = 1'b1;
    repeat (2) @(negedge Clk);
    check("idle_inready", 32'(ifa.InReady), 0);
    @(posedge Clk);
    #1 idle_a();

    // RTYPE, LW, SW(last) back-to-back.
    start_a();
    @(negedge Clk);
    check("run_inready", 32'(ifa.InReady), 1);
    @(posedge Clk);
    #1;
    send_a(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 1'b0, 32'h00221820, 1'b1);
    send_a(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 1'b0, 32'h8D280004, 1'b1);
    send_a(3'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0008, 1'b1, 32'hAD280008, 1'b1);
    idle_a();
    @(negedge Clk);
    check("t1_done_with_last_write", 32'(ifa.Done), 1);
    check("t1_count", 32'(ifa.Count), 3);
    check("t1_inready_done", 32'(ifa.InReady), 0);
    @(negedge Clk);
    check("t1_done_holds", 32'(ifa.Done), 1);
    check("t1_wren_pulse", 32'(ifa.WrEn), 0);
    @(posedge Clk);
    #1;

    // ADDI, ADDIU, filler, backward BRANCH at addr 3.
    start_a();
    send_a(3'd4, 5'd0, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 1'b0, 32'h20020005, 1'b1);
    send_a(3'd5, 5'd2, 5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF, 1'b0, 32'h2442FFFF, 1'b1);
    send_a(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 1'b0, 32'h00221820, 1'b1);
    send_a(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0001, 1'b1, 32'h1022FFFD, 1'b1);
    idle_a();
    @(negedge Clk);
    check("t2_done", 32'(ifa.Done), 1);
    @(posedge Clk);
    #1;

    // Forward BRANCH at addr 0 to target 5.
    start_a();
    send_a(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 1'b1, 32'h10220004, 1'b1);
    idle_a();
    @(negedge Clk);
    check("t3_count", 32'(ifa.Count), 1);
    @(posedge Clk);
    #1;

    // Illegal kind mid-stream, then Start recovers.
    start_a();
    send_a(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 1'b0, 32'h00221820, 1'b1);
    send_a(3'd6, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 1'b0, 32'h0, 1'b0);
    idle_a();
    @(negedge Clk);
    check("t4_error", 32'(ifa.Error), 1);
    check("t4_inready_err", 32'(ifa.InReady), 0);
    check("t4_no_write", 32'(ifa.WrEn), 0);
    check("t4_done_clear", 32'(ifa.Done), 0);
    @(posedge Clk);
    #1;
    start_a();
    @(negedge Clk);
    check("t4_error_cleared", 32'(ifa.Error), 0);
    check("t4_count_cleared", 32'(ifa.Count), 0);
    @(posedge Clk);
    #1;
    send_a(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 1'b1, 32'h8D280004, 1'b1);
    idle_a();
    @(negedge Clk);
    check("t4_done_after_restart", 32'(ifa.Done), 1);
    @(posedge Clk);
    #1;

    // Asynchronous reset mid-stream with InValid held.
    start_a();
    send_a(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 1'b0, 32'h00221820, 1'b1);
    send_a(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 1'b0, 32'h8D280004, 1'b1);
    ifa.Kind = 3'd2; ifa.Imm = 16'h0008;
    @(negedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    check("arst_wren",    32'(ifa.WrEn), 0);
    check("arst_wraddr",  32'(ifa.WrAddr), 0);
    check("arst_wrdata",  ifa.WrData, 0);
    check("arst_count",   32'(ifa.Count), 0);
    check("arst_inready", 32'(ifa.InReady), 0);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("arst_idle_inready", 32'(ifa.InReady), 0);
    end
    check("arst_idle_count", 32'(ifa.Count), 0);
    @(posedge Clk);
    #1 idle_a();

    // AW=2: four writes fill the memory, the fifth InValid errors out.
    ifb.Start = 1'b1;
    @(posedge Clk);
    #1 ifb.Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifb.Kind = 3'd0; ifb.Rs = 5'd1; ifb.Rt = 5'd2; ifb.Rd = 5'(i);
      ifb.Shamt = 5'd0; ifb.Funct = 6'h20; ifb.InValid = 1'b1;
      @(negedge Clk);
      check("b_fill_inready", 32'(ifb.InReady), 1);
      qb.push_back('{i, fill_word[i], i + 1});
      @(posedge Clk);
      #1;
    end
    ifb.Rd = 5'd4;
    @(negedge Clk);
    check("b_full_inready", 32'(ifb.InReady), 0);
    check("b_full_count", 32'(ifb.Count), 4);
    @(posedge Clk);
    #1 ifb.InValid = 1'b0;
    @(negedge Clk);
    check("b_overrun_error", 32'(ifb.Error), 1);
    check("b_overrun_no_write", 32'(ifb.WrEn), 0);

    repeat (2) @(posedge Clk);
    #1;
    check("a_queue_drained", 32'(qa.size()), 0);
    check("b_queue_drained", 32'(qb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
